binary_to_bcd_serial: RTL
=========================

# binary_to_bcd_serial

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits between a binary value source, such as the fibonacci counter, and the digit renderer that draws decimal digits on the pixel display. Compared with a fully combinational converter it uses far fewer gates, at the cost of NUMBER_WIDTH+1 cycles per conversion. It exposes a start/ready/valid handshake so that producers update the display only at a controlled rate.

## Interface
- NUMBER_WIDTH, default 16: width of the binary input. Legal range 4..32.
- DIGITS_COUNT, derived localparam: $rtoi($ceil(NUMBER_WIDTH * $log10(2))). Equals 5 for the default width.
- clk  input  1: single clock; all state changes on its rising edge.
- rst  input  1: reset, synchronous and active-high.
- start  input  1: request a conversion of `value`. Accepted only in a cycle where `ready`=1.
- value  input  NUMBER_WIDTH: unsigned binary operand, sampled on the accepting edge only.
- ready  output  1: converter is idle and will accept `start`.
- valid  output  1: one-cycle pulse; `bcd` has just been updated with a new result.
- bcd  output  4*DIGITS_COUNT: packed BCD result; digit 0 (units) is in bits [3:0]. Held between conversions.

## Operation
- States: IDLE, SHIFT. Encoding is the state enum from the shared package.
- IDLE:
  - `ready`=1.
  - On `start`=1: load shift register with `value`, clear the BCD accumulator, set the step counter to NUMBER_WIDTH, go to SHIFT.
- SHIFT: each cycle performs one step, then decrements the counter.
  - Adjust: every accumulator digit ≥5 gets +3 (4-bit add, no carry out).
  - Shift: the concatenation {accumulator, shift register} shifts left by 1.
- Last step (counter reaches 1):
  - The adjusted and shifted accumulator is written directly to `bcd`.
  - `valid` is registered high for the next cycle.
  - State returns to IDLE.
- Width rules:
  - Accumulator is 4*DIGITS_COUNT bits; the result always fits, so no overflow is possible.
  - Unused top bits of the most significant digit read 0.
  - Step counter width is $clog2(NUMBER_WIDTH+1).
- `start` while in SHIFT is ignored. No queuing; `value` changes during SHIFT have no effect.
- `bcd` changes only on a completing edge or on reset. It is never exposed mid-conversion.
- Reset at any time, including mid-SHIFT:
  - State → IDLE, accumulator and `bcd` → 0, `valid` → 0, `ready` → 1.
  - The conversion in progress is discarded, with no `valid` pulse.

## Timing
- Reset values: `ready`=1, `valid`=0, `bcd`=0.
- Conversion timeline, with `start` sampled at edge k while `ready`=1:
  - `ready`=0 from edge k.
  - The shift steps occur at edges k+1..k+NUMBER_WIDTH.
  - From edge k+NUMBER_WIDTH, `bcd` holds the new result, `valid`=1 for exactly one cycle, and `ready`=1.
- Latency is NUMBER_WIDTH cycles from the accepting edge to result visibility. Throughput is one conversion per NUMBER_WIDTH+1 cycles.
- Back-to-back: `start` held high in the `valid` cycle is accepted at the next edge. `bcd` keeps the previous result until the new conversion completes.
- `start` and `rst` in the same cycle: reset wins; nothing is accepted.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `bcd_pkg`:
  - state enum (IDLE, SHIFT);
  - constant function `digits_for_width(width)`, used by both this block and the digit renderer so the two stay consistent;
  - `BCD_DIGIT_W` = 4.
- Sub-module `bcd_digit_adjust`: combinational 4-bit "if ≥5 add 3". Instantiated DIGITS_COUNT times in a generate loop.
- Everything else (FSM, counter, shift register, output register) stays in this module.

## Test plan
- Reset then idle: hold `rst` 2 cycles → `ready`=1, `valid`=0, `bcd`=0x00000. No `valid` pulse while `start`=0.
- Value 0: `start`, `value`=0 → after 16 cycles `valid` pulses once; `bcd`=0x00000; `ready` returns high in the same cycle.
- Maximum value: `value`=65535 → `bcd`=0x65535, with `valid` exactly 16 cycles after the accepting edge. Repeat with `value`=46368 → `bcd`=0x46368.
- Busy rejection: `start`, `value`=12345, then pulse `start` with `value`=999 at step 5 → single `valid`, `bcd`=0x12345, `ready` low throughout.
- Reset mid-conversion: `start`, `value`=54321, assert `rst` at step 8 → no `valid`, `bcd`=0, `ready`=1. A following `start`, `value`=7 → `bcd`=0x00007.
- Back-to-back: keep `start` high with `value`=100 then 200 → `valid` at cycles 16 and 33 with `bcd` 0x00100 then 0x00200. `bcd` stays 0x00100 between the two pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD converter and the digit renderer, so both
// agree on digit count and digit width for any binary operand width.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ceil(width * log10(2)) in integer arithmetic; 0.30103 is accurate
    // enough that no width in 4..32 lands on the wrong side of an integer.
    function automatic int digits_for_width(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(5))
            dout = din + BCD_DIGIT_W'(3);
    end

endmodule

// File: rtl/binary_to_bcd_serial.sv
// Serial binary-to-BCD converter: one shift-and-add-3 step per clock, with a
// start/ready/valid handshake and a result register held between conversions.
module binary_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter  int NUMBER_WIDTH = 16,
    localparam int DIGITS_COUNT = digits_for_width(NUMBER_WIDTH),
    localparam int ACC_W        = BCD_DIGIT_W * DIGITS_COUNT,
    localparam int CNT_W        = $clog2(NUMBER_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUMBER_WIDTH-1:0] value,
    output logic                    ready,
    output logic                    valid,
    output logic [ACC_W-1:0]        bcd
);

    state_t                                     state;
    logic [NUMBER_WIDTH-1:0]                    sr;
    logic [CNT_W-1:0]                           cnt;
    logic [DIGITS_COUNT-1:0][BCD_DIGIT_W-1:0]   acc;
    logic [DIGITS_COUNT-1:0][BCD_DIGIT_W-1:0]   acc_adj;
    logic [ACC_W-1:0]                           adj_flat;
    logic [ACC_W-1:0]                           acc_next;

    for (genvar g = 0; g < DIGITS_COUNT; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (acc[g]),
            .dout (acc_adj[g])
        );
    end

    // Adjusted accumulator shifted left, taking the next binary MSB as its LSB.
    assign adj_flat = acc_adj;
    assign acc_next = {adj_flat[ACC_W-2:0], sr[NUMBER_WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            acc   <= '0;
            bcd   <= '0;
            valid <= 1'b0;
            ready <= 1'b1;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= value;
                        acc   <= '0;
                        cnt   <= CNT_W'(NUMBER_WIDTH);
                        ready <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    sr  <= {sr[NUMBER_WIDTH-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                    // Final step publishes straight from the step logic, saving a cycle.
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= acc_next;
                        valid <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
